gen_random_seq: RTL
===================

Name: gen_random_seq

Overview:
Parameterised, clocked successor to the combinational 2048 tile spawner. On a start pulse it snapshots an N×N board and counts the empty cells. It then picks one empty cell uniformly with an internal LFSR, writes a new tile (2, or optionally 4) there, and returns the updated board with a done pulse. It sits between the move/merge logic and the board register in the game datapath.

Parameters:
N, 4, board side length; board has N*N cells, N from 2 to 8
TILE_W, 12, bits per cell; value 0 means empty; tile holds the literal value (2, 4, 8, ...)
LFSR_W, 16, LFSR width; fixed polynomial x^16+x^14+x^13+x^11+1 when LFSR_W=16
SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a spawn; sampled only in IDLE
grid_in  in  N*N*TILE_W  board in; cell (r,c) = bits [(r*N+c)*TILE_W +: TILE_W]
grid_out  out  N*N*TILE_W  board after spawn; held until next done
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result valid
spawned  out  1  valid with done; 1 = a tile was placed
full  out  1  valid with done; 1 = no empty cell, board unchanged
spawn_idx  out  $clog2(N*N)  linear index of the placed cell
spawn_val  out  TILE_W  value placed (2 or 4)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - LFSR loads SEED.
  - grid_out, busy, done, spawned, full, spawn_idx and spawn_val all go to 0.
  - Reset mid-operation aborts the operation with no partial write.
- LFSR:
  - Free-runs, advancing one step every clock from reset release.
  - Holds no dependence on start.
- FSM states: IDLE, COUNT, PICK, PLACE, DONE.
- IDLE:
  - start=1 captures grid_in into the internal snapshot, clears empty count and scan index, then goes to COUNT.
  - start=0 stays in IDLE.
- COUNT:
  - Examines one cell per cycle, index 0 to N*N-1, incrementing the count when the cell is 0.
  - After the last cell, goes to PICK.
- PICK (1 cycle):
  - If count==0, sets full, leaves the snapshot unchanged and goes to DONE.
  - Otherwise latches target = lfsr % count and the value decision, then goes to PLACE.
  - Width rule: count is $clog2(N*N+1) bits; % is computed on the full LFSR_W value.
- PLACE:
  - Rescans cells 0 to N*N-1, one per cycle, keeping a running empty counter.
  - On the empty cell whose ordinal equals target, writes spawn_val into the snapshot and records spawn_idx.
  - Always scans all cells, then goes to DONE.
- DONE (1 cycle):
  - Copies the snapshot to grid_out.
  - Pulses done and drives spawned = !full, then returns to IDLE.
- Latency:
  - start sampled at cycle 0; done at cycle 2*N*N+2 when a tile is placed, N*N+2 when full.
  - For N=4: 34 cycles or 18 cycles.
- busy:
  - High for every cycle the FSM is in COUNT, PICK, PLACE or DONE.
- Back-to-back requests:
  - start while busy is ignored and not queued.
  - start in the cycle after done is accepted.
- full, spawned, spawn_idx and spawn_val:
  - Updated only at DONE; held until the next DONE.
  - When full=1, spawn_idx=0 and spawn_val=0.
- grid_in may change during an operation; only the snapshot is used.

Optional Feature:
SPAWN_FOUR_EN:
- Defined: in PICK, spawn_val=4 when lfsr[3:0]==4'h0 (1/16 probability), else 2.
- Undefined: spawn_val is always 2 and the LFSR low bits are unused for the value decision.

Decomposition:
- Package gen_random_pkg holds:
  - state enum type gen_state_t (IDLE, COUNT, PICK, PLACE, DONE)
  - constants TILE_EMPTY=0, SPAWN_LO=2, SPAWN_HI=4, default LFSR taps and seed
- One sub-module, lfsr_gen:
  - parameters W and SEED
  - ports clk, rst_n, q
  - free-running Fibonacci LFSR, reused later by other game blocks

Test Plan:
- Single empty cell: board all 8 except cell 5; start → done at cycle 34, spawned=1, full=0, spawn_idx=5, grid_out[5] ∈ {2,4}, other cells remain 8.
- Full board: all cells 8; start → done at cycle 18, full=1, spawned=0, grid_out equals the input.
- Four empty cells 0, 1, 2, 5, others 8: repeat 400 spawns with board restored each time → every pick is in {0,1,2,5} and each index occurs ≥60 times; only that cell changes.
- start held high for 40 cycles: exactly one done per accepted request (cycles 34 and 69); no request is accepted while busy.
- Reset mid-PLACE: rst_n=0 at cycle 20 → grid_out=0, busy=0, done=0 immediately; fresh start afterwards completes normally.
- SPAWN_FOUR_EN undefined: 200 spawns → spawn_val always 2. Defined: at least one 4 and at least 150 twos.

Source files
------------

// File: rtl/gen_random_pkg.sv
// Shared types and constants for the 2048 tile spawner and related game blocks.
package gen_random_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      PICK  = 3'd2,
      PLACE = 3'd3,
      DONE  = 3'd4
   } gen_state_t;

   localparam int TILE_EMPTY = 0;
   localparam int SPAWN_LO   = 2;
   localparam int SPAWN_HI   = 4;

   // x^16 + x^14 + x^13 + x^11 + 1 : feedback from bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   localparam logic [15:0] LFSR_SEED_16 = 16'hACE1;

endpackage

// File: rtl/gen_random_seq_lfsr.sv
// Free-running Fibonacci LFSR; advances every clock from reset release.
// SEED must be non-zero; TAPS defaults to the 16-bit maximal-length polynomial.
module lfsr_gen
   import gen_random_pkg::*;
#(
   parameter int           W    = 16,
   parameter logic [W-1:0] SEED = LFSR_SEED_16[W-1:0],
   parameter logic [W-1:0] TAPS = LFSR_TAPS_16[W-1:0]
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] q
);

   // Shift left, feeding the XOR of the tapped bits into bit 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= SEED;
      else        q <= {q[W-2:0], ^(q & TAPS)};
   end

endmodule

// File: rtl/gen_random_seq.sv
// 2048 tile spawner: snapshots an NxN board, counts empty cells, picks one
// uniformly with an LFSR and writes a new tile there.
// Optional macro SPAWN_FOUR_EN: spawn a 4 with 1/16 probability instead of always 2.
module gen_random_seq
   import gen_random_pkg::*;
#(
   parameter int                N      = 4,
   parameter int                TILE_W = 12,
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [N*N*TILE_W-1:0]    grid_in,
   output logic [N*N*TILE_W-1:0]    grid_out,
   output logic                     busy,
   output logic                     done,
   output logic                     spawned,
   output logic                     full,
   output logic [$clog2(N*N)-1:0]   spawn_idx,
   output logic [TILE_W-1:0]        spawn_val
);

   localparam int CELLS = N * N;
   localparam int IW    = $clog2(CELLS);
   localparam int CW    = $clog2(CELLS + 1);

   gen_state_t              state, state_nxt;
   logic [TILE_W-1:0]       snap [CELLS];
   logic [CELLS*TILE_W-1:0] snap_flat;
   logic [IW-1:0]           scan_idx;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           run_cnt;
   logic [IW-1:0]           target;
   logic [TILE_W-1:0]       val_pick;
   logic                    full_i;
   logic [IW-1:0]           idx_rec;
   logic [LFSR_W-1:0]       lfsr;
   logic                    last_cell;
   logic                    cell_empty;
   logic                    hit;

   // Reduce the full-width LFSR value modulo the empty count
   function automatic logic [IW-1:0] pick_target(input logic [LFSR_W-1:0] r,
                                                 input logic [CW-1:0]     c);
      logic [LFSR_W-1:0] m;
      m = r % LFSR_W'(c);
      return m[IW-1:0];
   endfunction

   lfsr_gen #(.W(LFSR_W), .SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   assign last_cell  = (scan_idx == IW'(CELLS - 1));
   assign cell_empty = (snap[scan_idx] == TILE_W'(TILE_EMPTY));
   assign hit        = cell_empty && (run_cnt == CW'(target));
   assign busy       = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: two linear scans separated by a single pick cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COUNT;
         COUNT:   if (last_cell) state_nxt = PICK;
         PICK:    state_nxt = (cnt == '0) ? DONE : PLACE;
         PLACE:   if (last_cell) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Flatten the snapshot back into the packed board layout
   always_comb begin
      snap_flat = '0;
      for (int i = 0; i < CELLS; i++) snap_flat[i*TILE_W +: TILE_W] = snap[i];
   end

   // Snapshot storage: load on accepted start, single tile write during PLACE
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         for (int i = 0; i < CELLS; i++) snap[i] <= grid_in[i*TILE_W +: TILE_W];
      end else if (state == PLACE && hit) begin
         snap[scan_idx] <= val_pick;
      end
   end

   // Scan counters, pick decision and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx  <= '0;
         cnt       <= '0;
         run_cnt   <= '0;
         target    <= '0;
         val_pick  <= '0;
         full_i    <= 1'b0;
         idx_rec   <= '0;
         grid_out  <= '0;
         done      <= 1'b0;
         spawned   <= 1'b0;
         full      <= 1'b0;
         spawn_idx <= '0;
         spawn_val <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  scan_idx <= '0;
                  cnt      <= '0;
                  full_i   <= 1'b0;
                  idx_rec  <= '0;
               end
            end
            COUNT: begin
               if (cell_empty) cnt <= cnt + 1'b1;
               scan_idx <= last_cell ? '0 : scan_idx + 1'b1;
            end
            PICK: begin
               run_cnt <= '0;
               if (cnt == '0) begin
                  full_i <= 1'b1;
               end else begin
                  target <= pick_target(lfsr, cnt);
`ifdef SPAWN_FOUR_EN
                  val_pick <= (lfsr[3:0] == 4'h0) ? TILE_W'(SPAWN_HI) : TILE_W'(SPAWN_LO);
`else
                  val_pick <= TILE_W'(SPAWN_LO);
`endif
               end
            end
            PLACE: begin
               if (hit) idx_rec <= scan_idx;
               if (cell_empty) run_cnt <= run_cnt + 1'b1;
               scan_idx <= last_cell ? '0 : scan_idx + 1'b1;
            end
            DONE: begin
               grid_out  <= snap_flat;
               done      <= 1'b1;
               spawned   <= !full_i;
               full      <= full_i;
               spawn_idx <= full_i ? '0 : idx_rec;
               spawn_val <= full_i ? '0 : val_pick;
            end
            default: ;
         endcase
      end
   end

endmodule
